bitmap_plot_sequencer: RTL and testbench

Owns an N-entry point list (x,y,valid) and a ROWS x COLS bitmap register array. On a start command it clears the bitmap row by row, then walks the point list one entry per cycle and sets bitmap[y][x] for each valid entry. The bitmap is readable combinationally for the LEDR/HEX display path. Host point-list writes are arbitrated against the running sequence: accepted only when idle.

---
 rtl/bitmap_plot_sequencer_pkg.sv | 14 +
 rtl/bitmap_plot_sequencer_if.sv | 35 +++
 rtl/bitmap_plot_sequencer_rowmem.sv | 36 +++
 rtl/bitmap_plot_sequencer.sv | 122 ++++++++++++
 tb/tb_bitmap_plot_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_plot_sequencer_pkg.sv
// Shared definitions for the bitmap plot sequencer: default sizes and FSM state encoding.
package bitmap_plot_sequencer_pkg;

    localparam int unsigned CW_DEF = 3;
    localparam int unsigned N_DEF  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StPlot  = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/bitmap_plot_sequencer_if.sv
// Host-side bus of the plot sequencer: point-list writes, sequence control/status, display read.
interface bitmap_plot_sequencer_if
    import bitmap_plot_sequencer_pkg::*;
#(
    parameter int unsigned CW   = CW_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned COLS = 2 ** CW
);
    localparam int unsigned IW = $clog2(N);

    logic            pt_wr_en;
    logic [IW-1:0]   pt_wr_idx;
    logic [CW-1:0]   pt_wr_x;
    logic [CW-1:0]   pt_wr_y;
    logic            pt_wr_valid;
    logic            start;
    logic            clear_only;
    logic            busy;
    logic            done;
    logic            wr_reject;
    logic [IW:0]     plotted_count;
    logic [CW-1:0]   rd_row;
    logic [COLS-1:0] rd_data;

    modport master (
        output pt_wr_en, pt_wr_idx, pt_wr_x, pt_wr_y, pt_wr_valid, start, clear_only, rd_row,
        input  busy, done, wr_reject, plotted_count, rd_data
    );

    modport slave (
        input  pt_wr_en, pt_wr_idx, pt_wr_x, pt_wr_y, pt_wr_valid, start, clear_only, rd_row,
        output busy, done, wr_reject, plotted_count, rd_data
    );

endinterface

// File: rtl/bitmap_plot_sequencer_rowmem.sv
// ROWS x COLS bitmap registers with a whole-row clear port, single-bit set port and async read.
module bitmap_plot_sequencer_rowmem #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    parameter int unsigned RW   = $clog2(ROWS),
    parameter int unsigned XW   = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_en,
    input  logic [RW-1:0]   clr_row,
    input  logic            set_en,
    input  logic [RW-1:0]   set_row,
    input  logic [XW-1:0]   set_col,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data
);

    logic [COLS-1:0] mem_q [ROWS];

    // Clear and set are never requested together; clear wins if they ever are.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_en) begin
            mem_q[clr_row] <= '0;
        end else if (set_en) begin
            mem_q[set_row][set_col] <= 1'b1;
        end
    end

    assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/bitmap_plot_sequencer.sv
// Clears the bitmap row by row, then plots every valid point-list entry; list writes only in idle.
module bitmap_plot_sequencer
    import bitmap_plot_sequencer_pkg::*;
#(
    parameter int unsigned CW   = CW_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned ROWS = 2 ** CW,
    parameter int unsigned COLS = 2 ** CW
) (
    input  logic CLOCK_50,
    input  logic reset,
    bitmap_plot_sequencer_if.slave bus
);

    localparam int unsigned IW = $clog2(N);

    logic [CW-1:0] pt_x_q [N];
    logic [CW-1:0] pt_y_q [N];
    logic [N-1:0]  pt_v_q;

    seq_state_e    state_q;
    logic [CW-1:0] row_ptr_q;
    logic [IW-1:0] pt_ptr_q;
    logic          clear_only_q;
    logic          busy_q;
    logic          done_q;
    logic          wr_reject_q;
    logic [IW:0]   count_q;

    logic          last_row;
    logic          last_pt;

    assign last_row = (row_ptr_q == CW'(ROWS - 1));
    assign last_pt  = (pt_ptr_q == IW'(N - 1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                pt_x_q[i] <= '0;
                pt_y_q[i] <= '0;
            end
            pt_v_q       <= '0;
            state_q      <= StIdle;
            row_ptr_q    <= '0;
            pt_ptr_q     <= '0;
            clear_only_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_reject_q  <= 1'b0;
            count_q      <= '0;
        end else begin
            done_q      <= 1'b0;
            wr_reject_q <= bus.pt_wr_en && (state_q != StIdle);
            if (bus.pt_wr_en && (state_q == StIdle)) begin
                pt_x_q[bus.pt_wr_idx] <= bus.pt_wr_x;
                pt_y_q[bus.pt_wr_idx] <= bus.pt_wr_y;
                pt_v_q[bus.pt_wr_idx] <= bus.pt_wr_valid;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q      <= StClear;
                        row_ptr_q    <= '0;
                        count_q      <= '0;
                        clear_only_q <= bus.clear_only;
                        busy_q       <= 1'b1;
                    end
                end
                StClear: begin
                    row_ptr_q <= row_ptr_q + CW'(1);
                    if (last_row) begin
                        if (clear_only_q) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= StPlot;
                            pt_ptr_q <= '0;
                        end
                    end
                end
                StPlot: begin
                    if (pt_v_q[pt_ptr_q]) begin
                        count_q <= count_q + {{IW{1'b0}}, 1'b1};
                    end
                    pt_ptr_q <= pt_ptr_q + IW'(1);
                    if (last_pt) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    bitmap_plot_sequencer_rowmem #(
        .ROWS(ROWS),
        .COLS(COLS),
        .RW  (CW),
        .XW  (CW)
    ) u_rowmem (
        .clk    (CLOCK_50),
        .rst    (reset),
        .clr_en (state_q == StClear),
        .clr_row(row_ptr_q),
        .set_en ((state_q == StPlot) && pt_v_q[pt_ptr_q]),
        .set_row(pt_y_q[pt_ptr_q]),
        .set_col(pt_x_q[pt_ptr_q]),
        .rd_row (bus.rd_row),
        .rd_data(bus.rd_data)
    );

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.wr_reject     = wr_reject_q;
    assign bus.plotted_count = count_q;

endmodule

// File: tb/tb_bitmap_plot_sequencer.sv
// Directed bench for bitmap_plot_sequencer with hand-computed bitmap and timing expectations.
module tb_bitmap_plot_sequencer;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   checks   = 0;
    int   passes   = 0;

    bitmap_plot_sequencer_if bus ();

    bitmap_plot_sequencer dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic write_pt(input int idx, input int x, input int y, input logic v);
        @(negedge CLOCK_50);
        bus.pt_wr_en    = 1'b1;
        bus.pt_wr_idx   = 3'(idx);
        bus.pt_wr_x     = 3'(x);
        bus.pt_wr_y     = 3'(y);
        bus.pt_wr_valid = v;
        @(negedge CLOCK_50);
        bus.pt_wr_en    = 1'b0;
    endtask

    // Leaves the bench just after the edge that samples start (edge 1).
    task automatic kick(input logic clr);
        @(negedge CLOCK_50);
        bus.start      = 1'b1;
        bus.clear_only = clr;
        @(posedge CLOCK_50);
        #1;
        bus.start      = 1'b0;
        bus.clear_only = 1'b0;
    endtask

    task automatic wait_done(input int already, output int edges);
        edges = already;
        while (bus.done !== 1'b1 && edges < 100) begin
            @(posedge CLOCK_50);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        for (int r = 0; r < 8; r++) begin
            bus.rd_row = 3'(r);
            #1;
            checks++;
            if (bus.rd_data !== 8'h00) $display("FAIL reset_row%0d got %h want 00", r, bus.rd_data);
            else passes++;
        end
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else passes++;
        checks++;
        if (bus.plotted_count !== 4'd0)
            $display("FAIL reset_count got %0d want 0", bus.plotted_count);
        else passes++;
    endtask

    task automatic test_plot();
        int edges;
        logic [7:0] exp_rows [8];
        exp_rows = '{8'h22, 8'h00, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h02};
        write_pt(0, 1, 0, 1'b1);
        write_pt(1, 5, 0, 1'b1);
        write_pt(2, 2, 2, 1'b1);
        write_pt(3, 3, 3, 1'b1);
        write_pt(5, 1, 7, 1'b1);
        kick(1'b0);
        wait_done(1, edges);
        checks++;
        if (edges !== 17) $display("FAIL plot_latency got %0d want 17", edges);
        else passes++;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL plot_busy_in_done got %b want 1", bus.busy);
        else passes++;
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL plot_after_done got done=%b busy=%b want 0 0", bus.done, bus.busy);
        else passes++;
        for (int r = 0; r < 8; r++) begin
            bus.rd_row = 3'(r);
            #1;
            checks++;
            if (bus.rd_data !== exp_rows[r])
                $display("FAIL plot_row%0d got %h want %h", r, bus.rd_data, exp_rows[r]);
            else passes++;
        end
        checks++;
        if (bus.plotted_count !== 4'd5)
            $display("FAIL plot_count got %0d want 5", bus.plotted_count);
        else passes++;
    endtask

    task automatic test_clear_only();
        int edges;
        kick(1'b1);
        wait_done(1, edges);
        checks++;
        if (edges !== 9) $display("FAIL clear_latency got %0d want 9", edges);
        else passes++;
        @(posedge CLOCK_50);
        #1;
        for (int r = 0; r < 8; r++) begin
            bus.rd_row = 3'(r);
            #1;
            checks++;
            if (bus.rd_data !== 8'h00) $display("FAIL clear_row%0d got %h want 00", r, bus.rd_data);
            else passes++;
        end
        checks++;
        if (bus.plotted_count !== 4'd0)
            $display("FAIL clear_count got %0d want 0", bus.plotted_count);
        else passes++;
    endtask

    task automatic test_write_reject();
        int edges;
        kick(1'b0);
        repeat (10) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.pt_wr_en    = 1'b1;
        bus.pt_wr_idx   = 3'd4;
        bus.pt_wr_x     = 3'd7;
        bus.pt_wr_y     = 3'd7;
        bus.pt_wr_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (bus.wr_reject !== 1'b1) $display("FAIL reject_pulse got %b want 1", bus.wr_reject);
        else passes++;
        @(negedge CLOCK_50);
        bus.pt_wr_en = 1'b0;
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (bus.wr_reject !== 1'b0) $display("FAIL reject_clear got %b want 0", bus.wr_reject);
        else passes++;
        wait_done(13, edges);
        checks++;
        if (edges !== 17) $display("FAIL reject_latency got %0d want 17", edges);
        else passes++;
        @(posedge CLOCK_50);
        #1;
        kick(1'b0);
        wait_done(1, edges);
        bus.rd_row = 3'd7;
        #1;
        checks++;
        if (bus.rd_data !== 8'h02) $display("FAIL reject_row7 got %h want 02", bus.rd_data);
        else passes++;
        checks++;
        if (bus.plotted_count !== 4'd5)
            $display("FAIL reject_count got %0d want 5", bus.plotted_count);
        else passes++;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset_mid_plot();
        int edges;
        logic saw_done;
        kick(1'b0);
        repeat (10) @(posedge CLOCK_50);
        #1;
        bus.rd_row = 3'd0;
        #1;
        checks++;
        if (bus.rd_data !== 8'h22) $display("FAIL midplot_row0 got %h want 22", bus.rd_data);
        else passes++;
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", bus.busy);
        else passes++;
        for (int r = 0; r < 8; r++) begin
            bus.rd_row = 3'(r);
            #1;
            checks++;
            if (bus.rd_data !== 8'h00)
                $display("FAIL midreset_row%0d got %h want 00", r, bus.rd_data);
            else passes++;
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge CLOCK_50);
            #1;
            saw_done = saw_done | bus.done;
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (10) begin
            @(posedge CLOCK_50);
            #1;
            saw_done = saw_done | bus.done;
        end
        checks++;
        if (saw_done !== 1'b0) $display("FAIL midreset_no_done got %b want 0", saw_done);
        else passes++;
        kick(1'b0);
        wait_done(1, edges);
        checks++;
        if (edges !== 17 || bus.plotted_count !== 4'd0)
            $display("FAIL midreset_rerun got edges=%0d count=%0d want 17 0", edges,
                     bus.plotted_count);
        else passes++;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_same_cycle_and_duplicate();
        int edges;
        @(negedge CLOCK_50);
        bus.start       = 1'b1;
        bus.pt_wr_en    = 1'b1;
        bus.pt_wr_idx   = 3'd6;
        bus.pt_wr_x     = 3'd0;
        bus.pt_wr_y     = 3'd4;
        bus.pt_wr_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.start    = 1'b0;
        bus.pt_wr_en = 1'b0;
        checks++;
        if (bus.wr_reject !== 1'b0) $display("FAIL same_cycle_reject got %b want 0", bus.wr_reject);
        else passes++;
        wait_done(1, edges);
        bus.rd_row = 3'd4;
        #1;
        checks++;
        if (bus.rd_data !== 8'h01 || bus.plotted_count !== 4'd1)
            $display("FAIL same_cycle got row4=%h count=%0d want 01 1", bus.rd_data,
                     bus.plotted_count);
        else passes++;
        @(posedge CLOCK_50);
        #1;
        write_pt(7, 0, 4, 1'b1);
        kick(1'b0);
        wait_done(1, edges);
        bus.rd_row = 3'd4;
        #1;
        checks++;
        if (bus.rd_data !== 8'h01 || bus.plotted_count !== 4'd2)
            $display("FAIL duplicate got row4=%h count=%0d want 01 2", bus.rd_data,
                     bus.plotted_count);
        else passes++;
        bus.rd_row = 3'd0;
        #1;
        checks++;
        if (bus.rd_data !== 8'h00) $display("FAIL duplicate_row0 got %h want 00", bus.rd_data);
        else passes++;
    endtask

    initial begin
        bus.pt_wr_en    = 1'b0;
        bus.pt_wr_idx   = '0;
        bus.pt_wr_x     = '0;
        bus.pt_wr_y     = '0;
        bus.pt_wr_valid = 1'b0;
        bus.start       = 1'b0;
        bus.clear_only  = 1'b0;
        bus.rd_row      = '0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        test_reset();
        test_plot();
        test_clear_only();
        test_write_reject();
        test_reset_mid_plot();
        test_same_cycle_and_duplicate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
